mem_access_stage: RTL and testbench

- MEM pipeline stage of the MIPS core. Sits between the EX/MEM pipeline register and the writeback stage.
- Issues load and store transactions to data memory over a req/ack handshake, then aligns and extends load data.
- Presents registered MEMRead, ALUResult and MemALUSel results to writeback.
- Stalls upstream while a bus transaction is outstanding. Aborts a transaction on timeout.

---
 rtl/mem_access_stage.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//   MEM pipeline stage of the MIPS core. Takes an instruction from the EX/MEM
//   register, performs the data-memory access (if any) over a req/ack bus,
//   aligns/extends load data and presents registered results to writeback.
//   Upstream is stalled (in_ready low) while a bus transaction is outstanding;
//   a transaction that sees no ack within TIMEOUT_CYCLES cycles is aborted and
//   reported as BusError.
//
// Parameters
//   TIMEOUT_CYCLES : cycles mem_req stays high without ack before abort (>= 1)
//   ADDR_W         : data-memory address width (<= 32, taken from ALUResult)
//
// Ports
//   clk, rst_n                       : clock (rising edge), async active-low reset
//   in_valid / in_ready              : EX/MEM handshake
//   ALUResult, StoreData             : address / ALU result, store data
//   MemRead, MemWrite, MemSize,
//   MemUnsigned                      : memory op control
//   RegWrite, MemALUSel, WriteReg    : writeback control carried through
//   mem_req/we/addr/be/wdata         : bus request side
//   mem_rdata, mem_ack               : bus response side
//   out_valid                        : one-cycle completion pulse
//   MEMRead, ALUResultOut,
//   MemALUSelOut, RegWriteOut,
//   WriteRegOut                      : registered results to writeback
//   AddrError, BusError              : error pulses, valid with out_valid
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       StoreData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        MemSize,
  input  logic              MemUnsigned,
  input  logic              RegWrite,
  input  logic              MemALUSel,
  input  logic [4:0]        WriteReg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [31:0]       MEMRead,
  output logic [31:0]       ALUResultOut,
  output logic              MemALUSelOut,
  output logic              RegWriteOut,
  output logic [4:0]        WriteRegOut,
  output logic              AddrError,
  output logic              BusError
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Access helpers
  // ---------------------------------------------------------------------------

  // Byte accesses are always aligned; size 11 behaves as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lo[0];
      default: mis = (lo != 2'b00);
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = 4'b0011 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the store data onto every lane lets the memory pick the lane
  // purely from mem_be.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic [1:0]  lo,
                                               input logic        uns,
                                               input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{lo, 3'b000} +: 8];
    h = rdata[{lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Latched request (drives the bus while in REQ)
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        lo_q, lo_d;
  logic              uns_q, uns_d;

  // Writeback fields carried across the bus transaction
  logic [31:0]       pend_alu_q, pend_alu_d;
  logic              pend_sel_q, pend_sel_d;
  logic              pend_rw_q, pend_rw_d;
  logic [4:0]        pend_wreg_q, pend_wreg_d;

  // Registered results
  logic              out_valid_q, out_valid_d;
  logic [31:0]       memread_q, memread_d;
  logic [31:0]       alu_out_q, alu_out_d;
  logic              sel_out_q, sel_out_d;
  logic              rw_out_q, rw_out_d;
  logic [4:0]        wreg_out_q, wreg_out_d;
  logic              addr_err_q, addr_err_d;
  logic              bus_err_q, bus_err_d;

  logic              acc_mem;
  logic              acc_mis;

  assign acc_mem = MemRead | MemWrite;
  assign acc_mis = is_misaligned(MemSize, ALUResult[1:0]);

  // Next-state and result computation for the IDLE/REQ controller
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    lo_d        = lo_q;
    uns_d       = uns_q;
    pend_alu_d  = pend_alu_q;
    pend_sel_d  = pend_sel_q;
    pend_rw_d   = pend_rw_q;
    pend_wreg_d = pend_wreg_q;
    out_valid_d = 1'b0;
    addr_err_d  = 1'b0;
    bus_err_d   = 1'b0;
    memread_d   = memread_q;
    alu_out_d   = alu_out_q;
    sel_out_d   = sel_out_q;
    rw_out_d    = rw_out_q;
    wreg_out_d  = wreg_out_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!acc_mem || acc_mis) begin
            // Completes in one cycle: plain ALU op, or misaligned access
            // rejected without touching the bus.
            out_valid_d = 1'b1;
            addr_err_d  = acc_mem;
            memread_d   = 32'h0000_0000;
            alu_out_d   = ALUResult;
            sel_out_d   = MemALUSel;
            rw_out_d    = RegWrite & ~acc_mem;
            wreg_out_d  = WriteReg;
          end else begin
            // Read+write together is a store: MemWrite alone decides we.
            state_d     = ST_REQ;
            cnt_d       = '0;
            we_d        = MemWrite;
            addr_d      = {ALUResult[ADDR_W-1:2], 2'b00};
            be_d        = byte_enables(MemSize, ALUResult[1:0]);
            wdata_d     = store_lanes(MemSize, StoreData);
            size_d      = MemSize;
            lo_d        = ALUResult[1:0];
            uns_d       = MemUnsigned;
            pend_alu_d  = ALUResult;
            pend_sel_d  = MemALUSel;
            pend_rw_d   = RegWrite;
            pend_wreg_d = WriteReg;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        // Ack wins over a timeout landing on the same cycle.
        if (mem_ack || (cnt_q == CNT_LAST)) begin
          state_d     = ST_IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          bus_err_d   = ~mem_ack;
          alu_out_d   = pend_alu_q;
          sel_out_d   = pend_sel_q;
          rw_out_d    = pend_rw_q & mem_ack;
          wreg_out_d  = pend_wreg_q;
          if (mem_ack && !we_q) begin
            memread_d = load_extract(size_q, lo_q, uns_q, mem_rdata);
          end else begin
            memread_d = 32'h0000_0000;
          end
        end else begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, request latch and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      size_q      <= 2'b00;
      lo_q        <= 2'b00;
      uns_q       <= 1'b0;
      pend_alu_q  <= 32'h0000_0000;
      pend_sel_q  <= 1'b0;
      pend_rw_q   <= 1'b0;
      pend_wreg_q <= 5'd0;
      out_valid_q <= 1'b0;
      memread_q   <= 32'h0000_0000;
      alu_out_q   <= 32'h0000_0000;
      sel_out_q   <= 1'b0;
      rw_out_q    <= 1'b0;
      wreg_out_q  <= 5'd0;
      addr_err_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      lo_q        <= lo_d;
      uns_q       <= uns_d;
      pend_alu_q  <= pend_alu_d;
      pend_sel_q  <= pend_sel_d;
      pend_rw_q   <= pend_rw_d;
      pend_wreg_q <= pend_wreg_d;
      out_valid_q <= out_valid_d;
      memread_q   <= memread_d;
      alu_out_q   <= alu_out_d;
      sel_out_q   <= sel_out_d;
      rw_out_q    <= rw_out_d;
      wreg_out_q  <= wreg_out_d;
      addr_err_q  <= addr_err_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // mem_req is a decode of the state flop, so async reset drops it at once.
  assign mem_req      = (state_q == ST_REQ);
  assign in_ready     = (state_q == ST_IDLE) && rst_n;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_be       = be_q;
  assign mem_wdata    = wdata_q;
  assign out_valid    = out_valid_q;
  assign MEMRead      = memread_q;
  assign ALUResultOut = alu_out_q;
  assign MemALUSelOut = sel_out_q;
  assign RegWriteOut  = rw_out_q;
  assign WriteRegOut  = wreg_out_q;
  assign AddrError    = addr_err_q;
  assign BusError     = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//   Directed and randomized checks of mem_access_stage (TIMEOUT_CYCLES=4)
//   against a byte-arithmetic reference model. Inputs change and outputs are
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALUResult;
  logic [31:0] StoreData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  MemSize;
  logic        MemUnsigned;
  logic        RegWrite;
  logic        MemALUSel;
  logic [4:0]  WriteReg;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic [31:0] MEMRead;
  logic [31:0] ALUResultOut;
  logic        MemALUSelOut;
  logic        RegWriteOut;
  logic [4:0]  WriteRegOut;
  logic        AddrError;
  logic        BusError;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .StoreData(StoreData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemSize(MemSize), .MemUnsigned(MemUnsigned),
    .RegWrite(RegWrite), .MemALUSel(MemALUSel), .WriteReg(WriteReg),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .MEMRead(MEMRead), .ALUResultOut(ALUResultOut),
    .MemALUSelOut(MemALUSelOut), .RegWriteOut(RegWriteOut),
    .WriteRegOut(WriteRegOut), .AddrError(AddrError), .BusError(BusError)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [31:0] addr, input logic [1:0] size);
    return (int'(addr % 4) % nbytes(size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] size);
    int v;
    v = ((1 << nbytes(size)) - 1) << int'(addr % 4);
    if (nbytes(size) == 4) v = 15;
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] size);
    logic [31:0] w;
    int n;
    n = nbytes(size);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] size, input bit uns);
    longint v;
    int     bits;
    bits = 8 * nbytes(size);
    if (bits == 32) return rdata;
    v = (longint'(rdata) >> (8 * int'(addr % 4))) & ((64'sd1 <<< bits) - 1);
    if (!uns && v >= (64'sd1 <<< (bits - 1))) v = v - (64'sd1 <<< bits);
    return v[31:0];
  endfunction

  // ---------------- one instruction, start to completion ----------------
  // delay: number of REQ cycles before ack (>= T means never ack).
  task automatic do_op(input string tag, input bit rd, input bit wr, input logic [1:0] sz,
                       input bit uns, input bit rw, input bit sel, input logic [4:0] wreg,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                       input int delay, input bit stray);
    bit          is_mem, mis, go_bus, tmo;
    logic [31:0] exp_rd;
    int          k, waitc;
    is_mem = rd | wr;
    mis    = is_mem && model_mis(addr, sz);
    go_bus = is_mem && !mis;
    tmo    = go_bus && (delay >= T);
    exp_rd = (go_bus && !tmo && !wr) ? model_load(rdata, addr, sz, uns) : 32'h0;

    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check_eq({tag, ".ready"}, {31'd0, in_ready}, 32'd1);

    in_valid = 1'b1; ALUResult = addr; StoreData = sd; MemRead = rd; MemWrite = wr;
    MemSize = sz; MemUnsigned = uns; RegWrite = rw; MemALUSel = sel; WriteReg = wreg;
    @(negedge clk);
    in_valid = 1'b0; ALUResult = $urandom; StoreData = $urandom;

    if (go_bus) begin
      k = 0;
      while (mem_req === 1'b1 && k < 40) begin
        check_eq({tag, ".we"},    {31'd0, mem_we}, {31'd0, wr});
        check_eq({tag, ".addr"},  mem_addr, addr & 32'hFFFF_FFFC);
        check_eq({tag, ".be"},    {28'd0, mem_be}, {28'd0, model_be(addr, sz)});
        check_eq({tag, ".wdata"}, mem_wdata, (wr ? model_wdata(sd, sz) : mem_wdata));
        check_eq({tag, ".stall"}, {30'd0, in_ready, out_valid}, 32'd0);
        if (k == delay) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = $urandom;
        end
        @(negedge clk);
        k++;
      end
      mem_ack = 1'b0;
      check_eq({tag, ".req_cycles"}, k, tmo ? T : delay + 1);
    end else begin
      check_eq({tag, ".no_req"}, {31'd0, mem_req}, 32'd0);
    end

    check_eq({tag, ".out_valid"}, {31'd0, out_valid},   32'd1);
    check_eq({tag, ".addr_err"},  {31'd0, AddrError},   {31'd0, mis});
    check_eq({tag, ".bus_err"},   {31'd0, BusError},    {31'd0, tmo});
    check_eq({tag, ".regwrite"},  {31'd0, RegWriteOut}, {31'd0, rw && !mis && !tmo});
    check_eq({tag, ".wreg"},      {27'd0, WriteRegOut}, {27'd0, wreg});
    check_eq({tag, ".alu_out"},   ALUResultOut, addr);
    check_eq({tag, ".sel"},       {31'd0, MemALUSelOut}, {31'd0, sel});
    check_eq({tag, ".memread"},   MEMRead, exp_rd);
    check_eq({tag, ".ready_done"}, {31'd0, in_ready}, 32'd1);

    if (stray) mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq({tag, ".pulse"}, {29'd0, out_valid, AddrError, BusError}, 32'd0);
    check_eq({tag, ".idle_req"}, {31'd0, mem_req}, 32'd0);
    check_eq({tag, ".hold"}, ALUResultOut, addr);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; ALUResult = 32'h0; StoreData = 32'h0;
    MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemUnsigned = 1'b0;
    RegWrite = 1'b0; MemALUSel = 1'b0; WriteReg = 5'd0; mem_rdata = 32'h0; mem_ack = 1'b0;

    #1;
    check_eq("rst.ctrl", {28'd0, mem_req, in_ready, out_valid, RegWriteOut}, 32'd0);
    check_eq("rst.data", MEMRead | ALUResultOut, 32'd0);
    check_eq("rst.err",  {30'd0, AddrError, BusError}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU op
    do_op("alu", 0, 0, 2'b10, 0, 1, 0, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0, 0);
    // Signed and unsigned byte loads, ack after 2 cycles
    do_op("lb",  1, 0, 2'b00, 0, 1, 1, 5'd7, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 0);
    do_op("lbu", 1, 0, 2'b00, 1, 1, 1, 5'd7, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 0);
    // Half store
    do_op("sh",  0, 1, 2'b01, 0, 0, 0, 5'd0, 32'h0000_0202, 32'hDEAD_BEEF, 32'h0, 1, 0);
    // Misaligned word load
    do_op("lw_mis", 1, 0, 2'b10, 0, 1, 1, 5'd9, 32'h0000_0301, 32'h0, 32'h0, 0, 0);
    // Timeout, followed by a stray ack
    do_op("tmo", 1, 0, 2'b10, 0, 1, 1, 5'd3, 32'h0000_0400, 32'h0, 32'h0, T, 1);
    // Ack on the last allowed cycle, read+write treated as store, reserved size
    do_op("ack_last", 1, 0, 2'b01, 0, 1, 1, 5'd4, 32'h0000_0502, 32'h0, 32'h1234_8001, T - 1, 0);
    do_op("rdwr", 1, 1, 2'b00, 0, 0, 0, 5'd1, 32'h0000_0601, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0);
    do_op("sz11", 1, 0, 2'b11, 0, 1, 1, 5'd2, 32'h0000_0700, 32'h0, 32'hCAFE_F00D, 0, 0);

    // Reset during REQ
    in_valid = 1'b1; ALUResult = 32'h0000_0800; MemRead = 1'b1; MemWrite = 1'b0;
    MemSize = 2'b10; RegWrite = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rreq.req", {31'd0, mem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rreq.drop", {29'd0, mem_req, in_ready, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rreq.noval", {30'd0, out_valid, mem_req}, 32'd0);
    do_op("post_rst", 0, 0, 2'b00, 0, 1, 1, 5'd31, 32'hA5A5_0F0F, 32'h0, 32'h0, 0, 0);

    // Randomized instructions
    for (int i = 0; i < 250; i++) begin
      int          kind, dly;
      bit          rd, wr;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      rd = 1'b0; wr = 1'b0;
      if (kind >= 2) begin
        rd = $urandom_range(0, 1);
        wr = !rd || ($urandom_range(0, 3) == 0);
      end
      dly = ($urandom_range(0, 5) == 0) ? T : $urandom_range(0, T - 1);
      a = $urandom;
      do_op("rnd", rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            a, $urandom, $urandom, dly, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
